ttt_game: RTL and testbench

//   Synchronous 3x3 tic-tac-toe referee for two players.
//   - Accepts one move per enabled clock, stores the board and alternates turns.
//   - Detects a win or a draw, then freezes the game.
//   - Self-contained leaf block: a UI/controller drives coordinates, a display reads the packed board.

---
 rtl/ttt_game.sv | 81 ++++++++
 tb/tb_ttt_game.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ttt_game.sv
// rtl/ttt_game.sv - 3x3 tic-tac-toe referee with registered board, turn and result
module ttt_game (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  data_in_x,
  input  logic [2:0]  data_in_y,
  output logic        winner,
  output logic        player,
  output logic        stop_game,
  output logic [17:0] board
);

  logic [17:0] r_board;
  logic        r_player;
  logic        r_winner;
  logic        r_stop;

  logic        w_in_range;
  logic [3:0]  w_idx;
  logic [1:0]  w_mark;
  logic        w_accept;
  logic [17:0] w_board_nxt;
  logic [8:0]  w_own;
  logic        w_line;
  logic        w_full;

  // Decode the requested cell, decide acceptance and evaluate the board with the new mark in place
  always_comb begin
    w_in_range  = (data_in_x <= 3'd2) && (data_in_y <= 3'd2);
    // Out-of-range coordinates are forced to cell 0 so the part-select stays inside the board
    w_idx       = w_in_range ? (4'(data_in_y[1:0]) * 4'd3 + 4'(data_in_x[1:0])) : 4'd0;
    w_mark      = r_player ? 2'b10 : 2'b01;
    w_accept    = enable && !r_stop && w_in_range && (r_board[{w_idx, 1'b0} +: 2] == 2'b00);
    w_board_nxt = r_board;
    w_board_nxt[{w_idx, 1'b0} +: 2] = w_mark;
    w_full      = 1'b1;
    w_own       = '0;
    for (int i = 0; i < 9; i++) begin
      w_own[i] = (w_board_nxt[2*i +: 2] == w_mark);
      if (w_board_nxt[2*i +: 2] == 2'b00) begin
        w_full = 1'b0;
      end
    end
    // Only the mover's mark can complete a line: the game freezes on the first line
    w_line = (w_own[0] & w_own[1] & w_own[2]) |
             (w_own[3] & w_own[4] & w_own[5]) |
             (w_own[6] & w_own[7] & w_own[8]) |
             (w_own[0] & w_own[3] & w_own[6]) |
             (w_own[1] & w_own[4] & w_own[7]) |
             (w_own[2] & w_own[5] & w_own[8]) |
             (w_own[0] & w_own[4] & w_own[8]) |
             (w_own[2] & w_own[4] & w_own[6]);
  end

  // Game state: reset clears everything; an accepted move commits the mark and the result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_board  <= '0;
      r_player <= 1'b0;
      r_winner <= 1'b0;
      r_stop   <= 1'b0;
    end else if (w_accept) begin
      r_board <= w_board_nxt;
      if (w_line) begin
        r_winner <= 1'b1;
        r_stop   <= 1'b1;
      end else if (w_full) begin
        r_stop   <= 1'b1;
      end else begin
        r_player <= ~r_player;
      end
    end
  end

  assign board     = r_board;
  assign player    = r_player;
  assign winner    = r_winner;
  assign stop_game = r_stop;

endmodule

// File: tb/tb_ttt_game.sv
// tb/tb_ttt_game.sv - self-checking bench for ttt_game with a rule-level game model
module tb_ttt_game;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  data_in_x;
  logic [2:0]  data_in_y;
  logic        winner;
  logic        player;
  logic        stop_game;
  logic [17:0] board;

  int errors;
  int checks;

  // Game model: one integer per cell (0 empty, 1 player 0, 2 player 1)
  int m_cell [9];
  int m_player;
  int m_winner;
  int m_stop;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                       '{0,3,6}, '{1,4,7}, '{2,5,8},
                       '{0,4,8}, '{2,4,6}};

  ttt_game dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data_in_x (data_in_x),
    .data_in_y (data_in_y),
    .winner    (winner),
    .player    (player),
    .stop_game (stop_game),
    .board     (board)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      b[2*i +: 2] = 2'(m_cell[i]);
    end
    return b;
  endfunction

  task automatic model_update(input int x, input int y, input bit en, input bit rst);
    int idx;
    int mark;
    bit won;
    bit full;
    if (rst) begin
      for (int i = 0; i < 9; i++) m_cell[i] = 0;
      m_player = 0;
      m_winner = 0;
      m_stop   = 0;
    end else if (en && m_stop == 0 && x <= 2 && y <= 2 && m_cell[3*y + x] == 0) begin
      idx  = 3*y + x;
      mark = m_player + 1;
      m_cell[idx] = mark;
      won = 0;
      for (int l = 0; l < 8; l++) begin
        if (m_cell[lines[l][0]] == mark && m_cell[lines[l][1]] == mark && m_cell[lines[l][2]] == mark)
          won = 1;
      end
      full = 1;
      for (int i = 0; i < 9; i++) begin
        if (m_cell[i] == 0) full = 0;
      end
      if (won) begin
        m_winner = 1;
        m_stop   = 1;
      end else if (full) begin
        m_stop = 1;
      end else begin
        m_player = 1 - m_player;
      end
    end
  endtask

  task automatic compare_model();
    chk("cyc_board",  int'(board),     int'(model_board()));
    chk("cyc_player", int'(player),    m_player);
    chk("cyc_winner", int'(winner),    m_winner);
    chk("cyc_stop",   int'(stop_game), m_stop);
  endtask

  task automatic step(input int x, input int y, input bit en, input bit rst);
    data_in_x = 3'(x);
    data_in_y = 3'(y);
    enable    = en;
    reset     = rst;
    @(posedge clk);
    model_update(x, y, en, rst);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    int draw_x [9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
    int draw_y [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    errors    = 0;
    checks    = 0;
    clk       = 1'b0;
    reset     = 1'b1;
    enable    = 1'b0;
    data_in_x = '0;
    data_in_y = '0;
    m_player  = 1;
    m_winner  = 1;
    m_stop    = 1;
    for (int i = 0; i < 9; i++) m_cell[i] = 3;

    // Reset state
    step(0, 0, 0, 1);
    chk("rst_board",  int'(board),     0);
    chk("rst_player", int'(player),    0);
    chk("rst_winner", int'(winner),    0);
    chk("rst_stop",   int'(stop_game), 0);

    // Column-0 win by player 0
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    step(0, 2, 1, 0);
    chk("win_board",  int'(board),     'h1249);
    chk("win_winner", int'(winner),    1);
    chk("win_stop",   int'(stop_game), 1);
    chk("win_player", int'(player),    0);

    // Move into an empty cell after the win is ignored
    step(2, 2, 1, 0);
    chk("frozen_board",  int'(board),     'h1249);
    chk("frozen_player", int'(player),    0);
    chk("frozen_stop",   int'(stop_game), 1);

    // Reset aborts the finished game
    step(2, 2, 1, 1);
    chk("rst2_board",  int'(board),     0);
    chk("rst2_winner", int'(winner),    0);
    chk("rst2_stop",   int'(stop_game), 0);
    chk("rst2_player", int'(player),    0);

    // Same cell twice: second attempt rejected
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("dup_player", int'(player),     1);
    chk("dup_cell0",  int'(board[1:0]), 1);
    chk("dup_cell1",  int'(board[3:2]), 0);

    // Out-of-range coordinates and enable low are ignored
    step(3, 1, 1, 0);
    step(2, 2, 0, 0);
    step(1, 7, 1, 0);
    step(7, 7, 1, 0);
    chk("rej_board",  int'(board),  1);
    chk("rej_player", int'(player), 1);

    // Full board with no line
    step(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      step(draw_x[i], draw_y[i], 1, 0);
      if (i == 7) chk("draw_pending_stop", int'(stop_game), 0);
    end
    chk("draw_board",  int'(board),     'h16A59);
    chk("draw_stop",   int'(stop_game), 1);
    chk("draw_winner", int'(winner),    0);
    chk("draw_player", int'(player),    0);

    // Game-over hold across further idle and strobed cycles
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    chk("draw_hold_board", int'(board), 'h16A59);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
